// File: rtl/vga_scan_timer_pkg.sv
// Shared 640x480@60 timing constants and a window-decode helper for the VGA scan timer.
// The timer honours the build macro VGA_SCAN_LOOKAHEAD_EN (see vga_scan_timer.sv).
package vga_timing_pkg;

  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1 << POS_W;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL     = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL     = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int HSYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HSYNC_END   = HSYNC_START + H_SYNC_DEF;
  localparam int VSYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VSYNC_END   = VSYNC_START + V_SYNC_DEF;

  // True when lo <= pos < hi.
  function automatic logic in_window(logic [POS_W-1:0] pos, int lo, int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

endpackage

// File: rtl/vga_scan_timer_if.sv
// Scan-timing bundle between the VGA scan timer (master) and the pixel shader (slave).
// pix_ce travels with the bundle because it paces every signal on it.
interface vga_scan_timer_if #(parameter int FRAME_W = 8);
  import vga_timing_pkg::*;

  logic               pix_ce;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  pix_ce,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

  modport slave (
    output pix_ce,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_scan_timer_wrap_counter.sv
// Modulo-N up-counter with enable and synchronous reset; wrap flags the terminal count N-1.
// count_next exposes the value the counter takes on the coming edge.
module wrap_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  assign wrap = (count == W'(N - 1));

  always_comb begin
    count_next = count;
    if (en) count_next = wrap ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_next;
  end

endmodule

// File: rtl/vga_scan_timer.sv
// VGA scan timer: pixel-enabled h/v counters with fully registered sync, display and strobes.
// Build macro VGA_SCAN_LOOKAHEAD_EN presents hpos/vpos one enabled pixel ahead of the decode.
module vga_scan_timer
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = 1'b0,
  parameter int FRAME_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  vga_scan_timer_if.master    scan
);

  localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_bad_params
    $error("vga_scan_timer: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOT, V_TOT, MAX_TOTAL);
  end

  logic [POS_W-1:0]   h_count, h_next, v_count, v_next;
  logic [POS_W-1:0]   dec_h, dec_v;
  logic               h_tc, v_tc, v_en;
  logic               hsync_q, vsync_q, display_q, line_q, frame_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  assign v_en = scan.pix_ce & h_tc;

  wrap_counter #(.N(H_TOT), .W(POS_W)) u_hcnt (
    .clk        (clk),
    .reset      (reset),
    .en         (scan.pix_ce),
    .count      (h_count),
    .count_next (h_next),
    .wrap       (h_tc)
  );

  wrap_counter #(.N(V_TOT), .W(POS_W)) u_vcnt (
    .clk        (clk),
    .reset      (reset),
    .en         (v_en),
    .count      (v_count),
    .count_next (v_next),
    .wrap       (v_tc)
  );

  // Decoding the pre-edge position makes the decode trail the counters by one pixel.
`ifdef VGA_SCAN_LOOKAHEAD_EN
  assign dec_h = h_count;
  assign dec_v = v_count;
`else
  assign dec_h = h_next;
  assign dec_v = v_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      display_q   <= 1'b1;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      line_q  <= scan.pix_ce & h_tc;
      frame_q <= scan.pix_ce & h_tc & v_tc;
      if (scan.pix_ce) begin
        hsync_q   <= in_window(dec_h, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_q   <= in_window(dec_v, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        display_q <= in_window(dec_h, 0, H_VISIBLE) && in_window(dec_v, 0, V_VISIBLE);
        if (h_tc && v_tc) frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign scan.hpos        = h_count;
  assign scan.vpos        = v_count;
  assign scan.hsync       = hsync_q;
  assign scan.vsync       = vsync_q;
  assign scan.display_on  = display_q;
  assign scan.line_start  = line_q;
  assign scan.frame_start = frame_q;
  assign scan.frame_count = frame_cnt_q;

endmodule
